// File: rtl/imem_fetch_arb.sv
// Two-requester instruction memory arbiter with a one-cycle registered response path.
// Define IMEM_ARB_RR_EN for round-robin; otherwise m0 has priority with an m1 starvation guard.
module imem_fetch_arb #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        rerr,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_inst
);

   logic [1:0] req;
   logic [1:0] gnt;
   logic       misaligned;
   logic       rerr_reg;

   assign req = {m1_req, m0_req};

`ifdef IMEM_ARB_RR_EN
   // 1 means m1 won most recently; the reset value makes m0 the first choice
   logic last_reg;

   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         if (req == 2'b11)
            gnt = last_reg ? 2'b01 : 2'b10;
         else
            gnt = req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_reg <= 1'b1;
      else if (gnt[0])
         last_reg <= 1'b0;
      else if (gnt[1])
         last_reg <= 1'b1;
   end
`else
   localparam int CW = $clog2(STARVE_LIMIT + 2);

   logic [CW-1:0] starve_reg;
   logic [CW-1:0] starve_next;
   logic          starve_hit;

   assign starve_hit = (starve_reg == CW'(STARVE_LIMIT));

   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         if (req == 2'b11)
            gnt = starve_hit ? 2'b10 : 2'b01;
         else
            gnt = req;
      end
   end

   // Counts m0 wins while m1 keeps waiting; saturates at the limit
   always_comb begin
      starve_next = starve_reg;
      if (!m1_req || gnt[1])
         starve_next = '0;
      else if (gnt[0] && !starve_hit)
         starve_next = starve_reg + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_reg <= '0;
      else
         starve_reg <= starve_next;
   end
`endif

   assign m0_gnt     = gnt[0];
   assign m1_gnt     = gnt[1];
   assign mem_addr   = gnt[1] ? m1_addr : (gnt[0] ? m0_addr : 32'h0);
   assign misaligned = |mem_addr[1:0];

   // Per-port response registers; rdata only moves when that port wins
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
         logic        rvalid_reg;
         logic [31:0] rdata_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rvalid_reg <= 1'b0;
               rdata_reg  <= 32'h0;
            end else begin
               rvalid_reg <= gnt[gi];
               if (gnt[gi])
                  rdata_reg <= misaligned ? 32'h0 : mem_inst;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rerr_reg <= 1'b0;
      else
         rerr_reg <= (|gnt) & misaligned;
   end

   assign m0_rvalid = g_rsp[0].rvalid_reg;
   assign m0_rdata  = g_rsp[0].rdata_reg;
   assign m1_rvalid = g_rsp[1].rvalid_reg;
   assign m1_rdata  = g_rsp[1].rdata_reg;
   assign rerr      = rerr_reg;

endmodule

// File: tb/tb_imem_fetch_arb.sv
// Self-checking bench for imem_fetch_arb: directed scenarios plus randomized traffic
// against a rule-level reference model; honours IMEM_ARB_RR_EN like the design.
module tb_imem_fetch_arb;

   localparam int LIM = 4;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr;
   logic        m0_gnt, m1_gnt;
   logic        m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        rerr;
   logic [31:0] mem_addr;
   logic [31:0] mem_inst;

   int errors = 0;
   int checks = 0;

   // reference model state
   int          waits;
   int          last;
   bit          ev [2];
   logic [31:0] ed [2];
   bit          eerr;

   imem_fetch_arb #(.STARVE_LIMIT(LIM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .rerr      (rerr),
      .mem_addr  (mem_addr),
      .mem_inst  (mem_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h100)
         return 32'h00500093;
      return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
   endfunction

   // Combinational instruction memory
   assign mem_inst = mem_fn(mem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic reset_model();
      waits = 0;
      last  = 1;
      ev[0] = 0;
      ev[1] = 0;
      ed[0] = 32'h0;
      ed[1] = 32'h0;
      eerr  = 0;
   endtask

   // One clock cycle, entered and left at a falling edge. win is the model's
   // winner, dwin the winner the DUT actually granted (-1 = none).
   task automatic cycle(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                        output int win, output int dwin);
      logic [31:0] ea;
      m0_req  = r0;
      m0_addr = a0;
      m1_req  = r1;
      m1_addr = a1;
      #1;
      if (r0 && r1) begin
`ifdef IMEM_ARB_RR_EN
         win = (last == 1) ? 0 : 1;
`else
         win = (waits == LIM) ? 1 : 0;
`endif
      end else if (r0)
         win = 0;
      else if (r1)
         win = 1;
      else
         win = -1;
      dwin = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
      ea = (win == 0) ? a0 : ((win == 1) ? a1 : 32'h0);
      chk("m0_gnt", m0_gnt, (win == 0));
      chk("m1_gnt", m1_gnt, (win == 1));
      chk("mem_addr", mem_addr, ea);
      chk("m0_rvalid", m0_rvalid, ev[0]);
      chk("m1_rvalid", m1_rvalid, ev[1]);
      chk("m0_rdata", m0_rdata, ed[0]);
      chk("m1_rdata", m1_rdata, ed[1]);
      chk("rerr", rerr, eerr);
`ifdef IMEM_ARB_RR_EN
      if (win >= 0)
         last = win;
`else
      if (!r1 || win == 1)
         waits = 0;
      else if (win == 0 && waits < LIM)
         waits++;
`endif
      ev[0] = 0;
      ev[1] = 0;
      eerr  = 0;
      if (win >= 0) begin
         ev[win] = 1;
         eerr    = (ea[1:0] != 2'b00);
         ed[win] = eerr ? 32'h0 : mem_fn(ea);
         $display("txn t=%0t m%0d addr=%h exp_data=%h exp_err=%0d", $time, win, ea, ed[win], eerr);
      end
      @(negedge clk);
   endtask

   initial begin
      int w, dw;
      int pat [10];
      bit p0, p1;
      logic [31:0] q0, q1;

      rst_n   = 1'b0;
      m0_req  = 1'b0;
      m1_req  = 1'b0;
      m0_addr = 32'h0;
      m1_addr = 32'h0;
      reset_model();

      // Outputs idle and no grants while held in reset, even with requests up
      repeat (2) @(negedge clk);
      m0_req = 1'b1;
      m1_req = 1'b1;
      #1;
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      chk("rst_m1_rdata", m1_rdata, 32'h0);
      chk("rst_rerr", rerr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Both requesting continuously from reset
`ifdef IMEM_ARB_RR_EN
      pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
      pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
      for (int i = 0; i < 10; i++) begin
         cycle(1, 32'h1000 + 32'(i * 4), 1, 32'h2000 + 32'(i * 4), w, dw);
         chk("grant_seq", 32'(dw), 32'(pat[i]));
      end
      cycle(0, 32'h0, 0, 32'h0, w, dw);

      // Single aligned fetch from m0
      cycle(1, 32'h100, 0, 32'h0, w, dw);
      chk("fetch_rvalid", m0_rvalid, 1);
      chk("fetch_rdata", m0_rdata, 32'h00500093);
      chk("fetch_rerr", rerr, 0);
      cycle(0, 32'h0, 0, 32'h0, w, dw);

      // Misaligned fetch from m1
      cycle(0, 32'h0, 1, 32'h102, w, dw);
      chk("misal_rvalid", m1_rvalid, 1);
      chk("misal_rdata", m1_rdata, 32'h0);
      chk("misal_rerr", rerr, 1);
      cycle(0, 32'h0, 0, 32'h0, w, dw);

      // m0 streams eight consecutive words
      for (int i = 0; i < 8; i++)
         cycle(1, 32'(i * 4), 0, 32'h0, w, dw);
      cycle(0, 32'h0, 0, 32'h0, w, dw);

      // Reset in the cycle after an m0 grant drops the pending response
      cycle(1, 32'h40, 0, 32'h0, w, dw);
      chk("pre_rst_rvalid", m0_rvalid, 1);
      rst_n  = 1'b0;
      m0_req = 1'b1;
      #1;
      chk("mid_rst_rvalid", m0_rvalid, 0);
      chk("mid_rst_rdata", m0_rdata, 32'h0);
      chk("mid_rst_gnt", m0_gnt, 0);
      chk("mid_rst_rerr", rerr, 0);
      reset_model();
      @(negedge clk);
      #1;
      chk("hold_rst_rvalid", m0_rvalid, 0);
      chk("hold_rst_gnt", m0_gnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle(0, 32'h0, 0, 32'h0, w, dw);

      // Randomized traffic: requests held until granted, occasionally withdrawn
      p0 = 0;
      p1 = 0;
      q0 = 32'h0;
      q1 = 32'h0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && $urandom_range(0, 9) < 6) begin
            p0 = 1;
            q0 = $urandom;
            if ($urandom_range(0, 3) != 0) q0[1:0] = 2'b00;
         end else if (p0 && $urandom_range(0, 15) == 0)
            p0 = 0;
         if (!p1 && $urandom_range(0, 9) < 6) begin
            p1 = 1;
            q1 = $urandom;
            if ($urandom_range(0, 3) != 0) q1[1:0] = 2'b00;
         end else if (p1 && $urandom_range(0, 15) == 0)
            p1 = 0;
         cycle(p0, q0, p1, q1, w, dw);
         if (w == 0) p0 = 0;
         if (w == 1) p1 = 0;
      end
      cycle(0, 32'h0, 0, 32'h0, w, dw);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
